// File: rtl/hazard_ctrl_sb_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_sb_if
//   Bundle of every signal between the pipeline datapath and the hazard /
//   forwarding controller.
//
//   master : the datapath side. Drives the register addresses, the stage
//            qualifiers and the branch outcome. Receives the forwarding
//            selects, stall/flush controls and MDU status.
//   slave  : the hazard controller (hazard_ctrl_sb).
//
//   Parameters
//     REG_AW : register address width
//     CNT_W  : width of the stall-cycle performance counter
// ---------------------------------------------------------------------------
interface hazard_ctrl_sb_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);

  // Decode stage
  logic [REG_AW-1:0] rs1_d;
  logic [REG_AW-1:0] rs2_d;
  logic              mdu_op_d;

  // Execute stage
  logic [REG_AW-1:0] rs1_e;
  logic [REG_AW-1:0] rs2_e;
  logic [REG_AW-1:0] rd_e;
  logic              memread_e;
  logic              mdu_start_e;
  logic              pc_src_e;

  // Memory and write-back stages
  logic [REG_AW-1:0] rd_m;
  logic [REG_AW-1:0] rd_w;
  logic              regwrite_m;
  logic              regwrite_w;

  // Controller outputs
  logic [1:0]        fwd_a_e;
  logic [1:0]        fwd_b_e;
  logic              stall_f;
  logic              stall_d;
  logic              flush_d;
  logic              flush_e;
  logic              mdu_busy;
  logic              mdu_wb;
  logic [REG_AW-1:0] mdu_rd;
  logic [CNT_W-1:0]  stall_cycles;
  logic              sb_err;

  modport master (
    output rs1_d, rs2_d, mdu_op_d,
    output rs1_e, rs2_e, rd_e, memread_e, mdu_start_e, pc_src_e,
    output rd_m, rd_w, regwrite_m, regwrite_w,
    input  fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e,
    input  mdu_busy, mdu_wb, mdu_rd, stall_cycles, sb_err
  );

  modport slave (
    input  rs1_d, rs2_d, mdu_op_d,
    input  rs1_e, rs2_e, rd_e, memread_e, mdu_start_e, pc_src_e,
    input  rd_m, rd_w, regwrite_m, regwrite_w,
    output fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e,
    output mdu_busy, mdu_wb, mdu_rd, stall_cycles, sb_err
  );

endinterface

// File: rtl/hazard_ctrl_sb.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_sb
//   Hazard and forwarding controller for the 5-stage RISC-V pipeline.
//   - E-stage operand forwarding from M (priority) and W.
//   - Load-use stall detection.
//   - Taken-branch flush, which overrides any stall.
//   - Per-register scoreboard for one non-pipelined multi-cycle MDU, with
//     an internal latency counter and a one-cycle write-back strobe.
//   - Saturating count of cycles in which D is held.
//
//   Ports
//     clk    : clock
//     reset  : asynchronous, active-high reset
//     hz     : hazard_ctrl_sb_if.slave; pipeline register addresses and
//              qualifiers in, forwarding selects / stall / flush / MDU
//              status / performance counter / error flag out
//
//   Parameters
//     REG_AW  : register address width (2**REG_AW registers)
//     MDU_LAT : cycles from the MDU start edge to the mdu_wb cycle (2..15)
//     CNT_W   : stall-cycle counter width
// ---------------------------------------------------------------------------
module hazard_ctrl_sb #(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  hazard_ctrl_sb_if.slave   hz
);

  localparam int NUM_REGS = 2 ** REG_AW;
  localparam int LAT_W    = 4;                       // holds MDU_LAT-1 <= 14
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MDU_LAT - 1);

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b01;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  mdu_state_e          state_q, state_nxt;
  logic [LAT_W-1:0]    lat_cnt_q;
  logic [NUM_REGS-1:0] pending_q, pending_nxt;
  logic [REG_AW-1:0]   mdu_rd_q;
  logic [CNT_W-1:0]    stall_cnt_q;
  logic                sb_err_q;

  // Derived MDU status (output process of the FSM)
  logic busy;
  logic wb;

  // Issue classification for an MDU op leaving E
  logic issue_ok;
  logic issue_bad;

  // Hazards
  logic lu_hazard;
  logic sb_hazard;
  logic stall;

  // -------------------------------------------------------------------------
  // Forwarding
  // -------------------------------------------------------------------------
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rd_m,
    input logic              we_m,
    input logic [REG_AW-1:0] rd_w,
    input logic              we_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    // x0 is hard-wired zero, so a write "to" it must never be forwarded.
    if (we_m && (rd_m == rs) && (rs != '0))
      sel = FWD_M;
    else if (we_w && (rd_w == rs) && (rs != '0))
      sel = FWD_W;
    return sel;
  endfunction

  always_comb begin
    hz.fwd_a_e = fwd_sel(hz.rs1_e, hz.rd_m, hz.regwrite_m, hz.rd_w, hz.regwrite_w);
    hz.fwd_b_e = fwd_sel(hz.rs2_e, hz.rd_m, hz.regwrite_m, hz.rd_w, hz.regwrite_w);
  end

  // -------------------------------------------------------------------------
  // Hazard detection and stall / flush generation
  // -------------------------------------------------------------------------
  always_comb begin
    lu_hazard = hz.memread_e && (hz.rd_e != '0) &&
                ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));

    // Register operands waiting on the MDU, plus a structural hazard for a
    // second MDU op while the unit is occupied or being claimed from E.
    sb_hazard = ((hz.rs1_d != '0) && pending_q[hz.rs1_d]) ||
                ((hz.rs2_d != '0) && pending_q[hz.rs2_d]) ||
                (hz.mdu_op_d && (busy || hz.mdu_start_e));

    // A taken branch discards D anyway, so holding it would be pointless.
    stall = (lu_hazard || sb_hazard) && !hz.pc_src_e;
  end

  always_comb begin
    hz.stall_f = stall;
    hz.stall_d = stall;
    hz.flush_d = hz.pc_src_e;
    // While D is held, E must receive a bubble instead of a duplicate.
    hz.flush_e = hz.pc_src_e || lu_hazard || sb_hazard;
  end

  // -------------------------------------------------------------------------
  // MDU sequencing FSM
  // -------------------------------------------------------------------------

  // State register
  // NOTE: every clocked process uses non-blocking (<=) assignments so all
  // registers sample the same pre-edge values; comb processes use blocking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_nxt;
  end

  // Output process: status is a pure function of the registered state.
  always_comb begin
    busy = (state_q == ST_BUSY);
    wb   = busy && (lat_cnt_q == '0);
  end

  // A new op may issue when idle, or in the completion cycle, because the
  // unit is free again from the next edge onward.
  always_comb begin
    issue_ok  = hz.mdu_start_e && (!busy || wb);
    issue_bad = hz.mdu_start_e && busy && !wb;
  end

  // Next-state process
  always_comb begin
    // NOTE: a default assignment first on every comb output keeps paths
    // without an explicit assignment from inferring a latch.
    state_nxt = state_q;
    unique case (state_q)
      ST_IDLE: if (issue_ok) state_nxt = ST_BUSY;
      ST_BUSY: if (wb)       state_nxt = issue_ok ? ST_BUSY : ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Scoreboard update: clear on completion first, then set on a new issue,
  // so a back-to-back op to the same register keeps its bit set.
  // -------------------------------------------------------------------------
  always_comb begin
    pending_nxt = pending_q;
    if (wb)
      pending_nxt[mdu_rd_q] = 1'b0;
    if (issue_ok && (hz.rd_e != '0))
      pending_nxt[hz.rd_e] = 1'b1;
  end

  // -------------------------------------------------------------------------
  // Datapath registers: latency counter, scoreboard, destination latch,
  // error flag and performance counter.
  // -------------------------------------------------------------------------
  // NOTE: the pending array is a flop bank, not a RAM, and must be reset:
  // a stale bit after reset would stall its register forever.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_cnt_q   <= '0;
      pending_q   <= '0;
      mdu_rd_q    <= '0;
      stall_cnt_q <= '0;
      sb_err_q    <= 1'b0;
    end else begin
      pending_q <= pending_nxt;

      if (issue_ok)
        lat_cnt_q <= LAT_INIT;
      else if (busy && (lat_cnt_q != '0))
        lat_cnt_q <= lat_cnt_q - LAT_W'(1);

      if (issue_ok)
        mdu_rd_q <= hz.rd_e;

      // An illegal issue leaves all MDU state untouched and is only flagged.
      if (issue_bad)
        sb_err_q <= 1'b1;

      if (stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Status outputs
  // -------------------------------------------------------------------------
  always_comb begin
    hz.mdu_busy     = busy;
    hz.mdu_wb       = wb;
    hz.mdu_rd       = mdu_rd_q;
    hz.stall_cycles = stall_cnt_q;
    hz.sb_err       = sb_err_q;
  end

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl_sb
//   Directed bench for hazard_ctrl_sb with MDU_LAT=4. Inputs change 1 ns
//   after the rising edge; outputs are compared mid-cycle.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl_sb;

  localparam int REG_AW  = 5;
  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  hazard_ctrl_sb_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  hazard_ctrl_sb #(
    .REG_AW (REG_AW),
    .MDU_LAT(MDU_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.rs1_d       = '0;
    bus.rs2_d       = '0;
    bus.mdu_op_d    = 1'b0;
    bus.rs1_e       = '0;
    bus.rs2_e       = '0;
    bus.rd_e        = '0;
    bus.memread_e   = 1'b0;
    bus.mdu_start_e = 1'b0;
    bus.pc_src_e    = 1'b0;
    bus.rd_m        = '0;
    bus.rd_w        = '0;
    bus.regwrite_m  = 1'b0;
    bus.regwrite_w  = 1'b0;
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs respond to freshly driven inputs.
  task automatic settle();
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    apply_reset();

    // ---------------- reset state ----------------
    check("rst_busy",   32'(bus.mdu_busy),     0);
    check("rst_wb",     32'(bus.mdu_wb),       0);
    check("rst_rd",     32'(bus.mdu_rd),       0);
    check("rst_cnt",    32'(bus.stall_cycles), 0);
    check("rst_err",    32'(bus.sb_err),       0);
    check("rst_stall",  32'(bus.stall_d),      0);

    // ---------------- forwarding ----------------
    bus.regwrite_m = 1'b1; bus.rd_m = 5'd5;
    bus.regwrite_w = 1'b1; bus.rd_w = 5'd5;
    bus.rs1_e = 5'd5; bus.rs2_e = 5'd0;
    settle();
    check("fwd_a_m_prio", 32'(bus.fwd_a_e), 32'b10);
    check("fwd_b_none",   32'(bus.fwd_b_e), 32'b00);

    bus.rd_w = 5'd0;
    settle();
    check("fwd_b_x0", 32'(bus.fwd_b_e), 32'b00);

    bus.regwrite_m = 1'b0; bus.rd_w = 5'd5;
    settle();
    check("fwd_a_w", 32'(bus.fwd_a_e), 32'b01);

    bus.regwrite_m = 1'b1; bus.rd_m = 5'd5;
    bus.rs2_e = 5'd6; bus.rd_w = 5'd6;
    settle();
    check("fwd_a_m",  32'(bus.fwd_a_e), 32'b10);
    check("fwd_b_w",  32'(bus.fwd_b_e), 32'b01);

    bus.regwrite_w = 1'b0;
    settle();
    check("fwd_b_we0", 32'(bus.fwd_b_e), 32'b00);

    bus.rs1_e = 5'd0; bus.rd_m = 5'd0;
    settle();
    check("fwd_a_x0m", 32'(bus.fwd_a_e), 32'b00);
    idle_inputs();

    // ---------------- load-use ----------------
    bus.memread_e = 1'b1; bus.rd_e = 5'd7; bus.rs2_d = 5'd7;
    settle();
    check("lu_stall_f", 32'(bus.stall_f), 1);
    check("lu_stall_d", 32'(bus.stall_d), 1);
    check("lu_flush_e", 32'(bus.flush_e), 1);
    check("lu_flush_d", 32'(bus.flush_d), 0);
    step();
    check("lu_cnt1", 32'(bus.stall_cycles), 1);

    bus.rd_e = 5'd0; bus.rs2_d = 5'd0;
    settle();
    check("lu_x0_stall", 32'(bus.stall_d), 0);
    check("lu_x0_flush", 32'(bus.flush_e), 0);
    step();
    check("lu_cnt_hold", 32'(bus.stall_cycles), 1);
    idle_inputs();

    // ---------------- MDU scoreboard ----------------
    apply_reset();
    bus.mdu_start_e = 1'b1; bus.rd_e = 5'd9; bus.rs1_d = 5'd9;
    settle();
    check("mdu_c0_stall", 32'(bus.stall_d), 0);
    step();
    bus.mdu_start_e = 1'b0; bus.rd_e = 5'd0;
    for (int c = 1; c <= MDU_LAT; c++) begin
      settle();
      check($sformatf("mdu_c%0d_stall", c), 32'(bus.stall_d), 1);
      check($sformatf("mdu_c%0d_busy", c),  32'(bus.mdu_busy), 1);
      check($sformatf("mdu_c%0d_wb", c),    32'(bus.mdu_wb), (c == MDU_LAT) ? 1 : 0);
      if (c == MDU_LAT) check("mdu_wb_rd", 32'(bus.mdu_rd), 9);
      step();
    end
    check("mdu_c5_stall", 32'(bus.stall_d),      0);
    check("mdu_c5_busy",  32'(bus.mdu_busy),     0);
    check("mdu_cnt4",     32'(bus.stall_cycles), 4);

    // ---------------- branch priority ----------------
    bus.mdu_start_e = 1'b1; bus.rd_e = 5'd9;
    step();
    bus.mdu_start_e = 1'b0; bus.rd_e = 5'd0; bus.pc_src_e = 1'b1;
    settle();
    check("br_flush_d", 32'(bus.flush_d), 1);
    check("br_flush_e", 32'(bus.flush_e), 1);
    check("br_stall_f", 32'(bus.stall_f), 0);
    check("br_stall_d", 32'(bus.stall_d), 0);
    bus.pc_src_e = 1'b0; bus.rs1_d = 5'd0;
    for (int i = 0; i < 10 && bus.mdu_busy; i++) step();
    check("br_drain_busy", 32'(bus.mdu_busy), 0);

    // ---------------- back-to-back issue ----------------
    apply_reset();
    bus.mdu_start_e = 1'b1; bus.rd_e = 5'd3;
    step();
    bus.mdu_start_e = 1'b0; bus.rd_e = 5'd0; bus.mdu_op_d = 1'b1;
    for (int c = 1; c <= MDU_LAT; c++) begin
      settle();
      check($sformatf("b2b_c%0d_stall", c), 32'(bus.stall_d), 1);
      check($sformatf("b2b_c%0d_wb", c),    32'(bus.mdu_wb), (c == MDU_LAT) ? 1 : 0);
      step();
    end
    settle();
    check("b2b_release", 32'(bus.stall_d), 0);
    // The second op has advanced to E and issues in this window.
    bus.mdu_op_d = 1'b0; bus.mdu_start_e = 1'b1; bus.rd_e = 5'd4;
    settle();
    step();
    bus.mdu_start_e = 1'b0; bus.rd_e = 5'd0; bus.rs2_d = 5'd4;
    settle();
    check("b2b_busy",  32'(bus.mdu_busy), 1);
    check("b2b_rd",    32'(bus.mdu_rd),   4);
    check("b2b_dep",   32'(bus.stall_d),  1);
    check("b2b_err0",  32'(bus.sb_err),   0);

    // ---------------- illegal issue (cycle 1 of op on x4) ----------------
    bus.mdu_start_e = 1'b1; bus.rd_e = 5'd12;
    settle();
    check("ill_err_pre", 32'(bus.sb_err), 0);
    step();
    bus.mdu_start_e = 1'b0; bus.rd_e = 5'd0;
    bus.rs1_d = 5'd12; bus.rs2_d = 5'd0;
    settle();
    check("ill_err",     32'(bus.sb_err),  1);
    check("ill_rd_kept", 32'(bus.mdu_rd),  4);
    check("ill_no_pend", 32'(bus.stall_d), 0);
    check("ill_c2_wb",   32'(bus.mdu_wb),  0);
    step();
    check("ill_c3_wb",   32'(bus.mdu_wb),  0);
    step();
    check("ill_c4_wb",   32'(bus.mdu_wb),  1);
    check("ill_c4_rd",   32'(bus.mdu_rd),  4);

    // Same-cycle completion and new issue to the same register.
    bus.rs1_d = 5'd0; bus.rs2_d = 5'd4;
    bus.mdu_start_e = 1'b1; bus.rd_e = 5'd4;
    settle();
    check("same_wb_stall", 32'(bus.stall_d), 1);
    step();
    bus.mdu_start_e = 1'b0; bus.rd_e = 5'd0;
    settle();
    check("same_busy",    32'(bus.mdu_busy), 1);
    check("same_pend",    32'(bus.stall_d),  1);
    check("same_wb0",     32'(bus.mdu_wb),   0);
    check("same_err",     32'(bus.sb_err),   1);
    check("same_cnt_nz",  32'(bus.stall_cycles != '0), 1);

    // ---------------- asynchronous reset at counter=2 ----------------
    step();                      // now in cycle 2 of the op (counter = 2)
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy",  32'(bus.mdu_busy),     0);
    check("arst_wb",    32'(bus.mdu_wb),       0);
    check("arst_err",   32'(bus.sb_err),       0);
    check("arst_cnt",   32'(bus.stall_cycles), 0);
    check("arst_rd",    32'(bus.mdu_rd),       0);
    check("arst_pend",  32'(bus.stall_d),      0);
    bus.memread_e = 1'b1; bus.rd_e = 5'd4;
    settle();
    check("arst_lu",    32'(bus.stall_d),      1);
    #2;
    reset = 1'b0;
    idle_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_sb.md
Name: hazard_ctrl_sb

Overview:
- Next-generation hazard/forwarding controller for the 5-stage pipelined RISC-V core.
- Adds the following to plain E-stage forwarding:
  - load-use stall detection,
  - taken-branch flush,
  - a per-register scoreboard for one non-pipelined multi-cycle MDU (mul/div) with an internal latency counter,
  - a stall-cycle performance counter.
- Sits beside the datapath. Drives forwarding muxes in E, stall enables for F/D, flush controls for D/E, and the MDU write-back strobe.

Parameters:
- REG_AW, 5, register address width; the register file has 2**REG_AW entries.
- MDU_LAT, 4, MDU latency in cycles from start to result valid; legal range 2..15.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- rs1_d, rs2_d  in  REG_AW  source registers of the instruction in D
- mdu_op_d  in  1  instruction in D is an MDU op
- rs1_e, rs2_e, rd_e  in  REG_AW  source and destination registers of the instruction in E
- memread_e  in  1  instruction in E is a load
- mdu_start_e  in  1  MDU op issuing from E this cycle
- pc_src_e  in  1  branch or jump taken, resolved in E
- rd_m, rd_w  in  REG_AW  destination registers in M and W
- regwrite_m, regwrite_w  in  1  write enables in M and W
- fwd_a_e, fwd_b_e  out  2  forwarding selects for the E operands: 00 register file, 10 from M, 01 from W
- stall_f, stall_d  out  1  hold the PC and the IF/ID register
- flush_d, flush_e  out  1  clear the IF/ID and ID/EX registers
- mdu_busy  out  1  MDU operation in flight
- mdu_wb  out  1  one-cycle pulse: MDU result valid this cycle
- mdu_rd  out  REG_AW  destination of the completing MDU op
- stall_cycles  out  CNT_W  saturating count of cycles with stall_d=1
- sb_err  out  1  sticky flag: illegal MDU issue while busy

Behaviour:
- Forwarding (combinational):
  - fwd_a_e = 10 if regwrite_m && rd_m==rs1_e && rs1_e!=0.
  - Otherwise fwd_a_e = 01 if regwrite_w && rd_w==rs1_e && rs1_e!=0.
  - Otherwise fwd_a_e = 00.
  - M has priority over W. fwd_b_e is identical using rs2_e.
- Load-use hazard (lu): memread_e && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d).
- Scoreboard hazard (sb):
  - pending[rs1_d] or pending[rs2_d] is set (x0 excluded), or
  - mdu_op_d && (mdu_busy || mdu_start_e).
- Stall outputs:
  - stall_f = stall_d = (lu || sb) && !pc_src_e.
  - flush_e = pc_src_e || lu || sb. A bubble is inserted whenever D is held.
  - flush_d = pc_src_e. A taken branch overrides any stall.
- Scoreboard (registered, one pending bit per register):
  - Set: on mdu_start_e && !mdu_busy, set pending[rd_e] (skipped if rd_e==0), latch mdu_rd<=rd_e, and load the counter with MDU_LAT-1. mdu_busy goes high the next cycle.
  - Count: while busy, the counter decrements each cycle.
  - Complete: when busy and counter==0, mdu_wb=1 for exactly that cycle and pending[mdu_rd] clears at the following edge. mdu_busy deasserts at the following edge.
  - Total: MDU_LAT cycles from the start edge to the mdu_wb cycle.
  - Same-cycle clear and new start are legal. The new start sets its bit after the clear, so the set wins when both target the same register.
  - A D instruction reading mdu_rd unstalls the cycle after mdu_wb. Its value arrives through the W/register-file path; there is no forwarding from the MDU.
- Illegal issue: mdu_start_e while mdu_busy && !mdu_wb is ignored (no state change) and sets sb_err=1 until reset.
- stall_cycles: increments on each cycle with stall_d=1 and saturates at all-ones.
- Reset (any time, including mid-MDU-op):
  - pending, counter, mdu_busy, mdu_wb, mdu_rd, stall_cycles and sb_err all go to 0.
  - Combinational outputs follow their inputs; with no pending state, stall_d depends only on lu.

Test Plan:
- Forwarding: regwrite_m=1, rd_m=5; regwrite_w=1, rd_w=5; rs1_e=5; rs2_e=0 with rd_w=0 -> fwd_a_e=10 (M priority), fwd_b_e=00 (x0 never forwarded).
- Load-use: memread_e=1, rd_e=7, rs2_d=7 -> stall_f=stall_d=1, flush_e=1 for one cycle; the same case with rd_e=0 -> no stall.
- MDU scoreboard, MDU_LAT=4:
  - Stimulus: mdu_start_e with rd_e=9 at cycle 0; D holds rs1_d=9.
  - Required: stall_d=1 in cycles 1..4; mdu_wb=1 with mdu_rd=9 at cycle 4; stall_d=0 at cycle 5.
  - stall_cycles=4 afterwards.
- Branch priority: pc_src_e=1 during an sb stall -> flush_d=flush_e=1, stall_f=stall_d=0.
- Back-to-back and illegal issue:
  - A second MDU op in D while busy -> stall_d until completion, then it issues in the mdu_wb+1 window.
  - Forced mdu_start_e mid-op -> sb_err=1; pending and the counter are unchanged.
- Reset asserted at counter=2 -> mdu_busy=0, pending cleared, sb_err=0, stall_cycles=0 asynchronously, before the next clock edge.
